mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one memory port between two masters: the instruction fetch port (read-only) and the data access port (read/write). Sits between the pipeline stages and the unified memory/cache slave. All three ports use the memory_bus signal set: word address, write data, read data, read, write, ready, byte select.
- Fixed data-over-instruction priority.
- A starvation counter guarantees that fetch progresses.
- Request fields are latched at grant, so a held transaction cannot be corrupted by master-side changes.

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width
STARVE_LIMIT, 4, number of consecutive lost arbitrations after which the instruction port wins the next one (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_addr  in  ADDR_W  instruction request address
i_read  in  1  instruction read request
i_ready  out  1  instruction data valid
i_dataQ  out  DATA_W  instruction read data
d_addr  in  ADDR_W  data request address
d_dataD  in  DATA_W  data write data
d_read  in  1  data read request
d_write  in  1  data write request
d_byteSel  in  4  data byte enables
d_ready  out  1  data access complete
d_dataQ  out  DATA_W  data read data
m_addr  out  ADDR_W  slave address
m_dataD  out  DATA_W  slave write data
m_read  out  1  slave read
m_write  out  1  slave write
m_byteSel  out  4  slave byte enables
m_ready  in  1  slave completion
m_dataQ  in  DATA_W  slave read data
grant_o  out  2  current owner: 00 none, 01 inst, 10 data

Behaviour:
- Reset:
  - State IDLE, starve counter 0, latched request cleared.
  - While rst=1, all outputs are forced inactive: m_read=m_write=0, i_ready=d_ready=0, grant_o=00, m_addr/m_dataD=0, m_byteSel=0.
- Requests are level-signalled. A master holds read/write asserted until it sees its ready. d_read and d_write are mutually exclusive; if both are asserted, the write is performed.
- The instruction port always drives m_byteSel=4'b1111 and m_write=0.
- IDLE:
  - Winner is chosen combinationally. It is data if d_read|d_write, unless the starve counter equals STARVE_LIMIT and i_read=1, in which case inst wins. If only one port requests, that port wins.
  - The winner's fields go straight to m_* in the same cycle, giving zero added latency. grant_o shows the winner.
  - If m_ready=1 in that cycle, the winner's ready is asserted and the state stays IDLE.
  - Otherwise the winner's fields are latched and the state moves to BUSY_I or BUSY_D.
- BUSY_I / BUSY_D:
  - m_* are driven from the latched fields; input changes from either master are ignored.
  - On m_ready=1: the owner's ready=1, then IDLE next cycle. A new grant happens no earlier than the following cycle.
- Ready routing:
  - m_dataQ is routed to both i_dataQ and d_dataQ unconditionally.
  - Only the owner, or the IDLE winner, sees ready=1. The non-owner's ready is always 0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) at each grant decision where i_read=1 and data wins.
  - Clears to 0 on any grant to inst.
  - Holds when i_read=0.
- m_ready while IDLE with no request is ignored. A transaction interrupted by reset is abandoned; the slave must be reset with the arbiter.
- No outstanding transactions: exactly one transaction is in flight at a time.

Test Plan:
- Inst only, i_addr=30'h100, i_read=1, slave ready after 2 cycles -> m_addr=30'h100, m_read=1 for 3 cycles, i_ready=1 on the 3rd cycle only with i_dataQ=m_dataQ, grant_o 01, d_ready=0 throughout.
- Simultaneous i_read and d_write (d_addr=30'h20, d_dataD=32'hDEADBEEF, d_byteSel=4'b0011), zero-wait slave -> data granted first (m_write=1, m_byteSel=0011, d_ready=1 same cycle). Inst is granted the next cycle, then i_ready=1.
- Data port requesting continuously, i_read held, STARVE_LIMIT=4, 1-cycle-wait slave -> data wins 4 grants. The 5th grant goes to inst (grant_o=01), and the counter returns to 0.
- Owner latch: BUSY_D on addr 30'h40, then d_addr changes to 30'h80 mid-wait -> m_addr stays 30'h40 until m_ready.
- Reset mid-transaction: rst=1 during BUSY_I -> next cycle m_read=0, grant_o=00, i_ready=0. After rst deassert, a new i_read is granted from IDLE normally.
- d_read and d_write both asserted -> m_write=1, m_read=0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_bus_arbiter_if                                            |
// | Purpose  : Signal bundle for the two-master memory arbiter. Carries the  |
// |            instruction fetch port (i_*), the data access port (d_*) and  |
// |            the shared slave port (m_*).                                  |
// | Modports : slave  - arbiter seen as a slave by the pipeline masters      |
// |                     (takes i_/d_ requests, returns ready and read data)  |
// |            master - arbiter seen as a master by the memory/cache slave   |
// |                     (drives m_ requests, takes m_ready and m_dataQ)      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   // instruction fetch port (read-only)
   logic [ADDR_W-1:0] i_addr;
   logic              i_read;
   logic              i_ready;
   logic [DATA_W-1:0] i_dataQ;
   // data access port
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_dataD;
   logic              d_read;
   logic              d_write;
   logic [3:0]        d_byteSel;
   logic              d_ready;
   logic [DATA_W-1:0] d_dataQ;
   // shared slave port
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_dataD;
   logic              m_read;
   logic              m_write;
   logic [3:0]        m_byteSel;
   logic              m_ready;
   logic [DATA_W-1:0] m_dataQ;

   modport slave (
      input  i_addr, i_read, d_addr, d_dataD, d_read, d_write, d_byteSel,
      output i_ready, i_dataQ, d_ready, d_dataQ
   );

   modport master (
      output m_addr, m_dataD, m_read, m_write, m_byteSel,
      input  m_ready, m_dataQ
   );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_bus_arbiter                                               |
// | Purpose  : Shares one memory port between the instruction fetch port     |
// |            and the data access port. Data has fixed priority; a starve  |
// |            counter lets fetch win after STARVE_LIMIT lost decisions.     |
// |            The IDLE winner is passed straight through (zero latency);    |
// |            a transaction that waits is held from latched fields.        |
// | Ports    : clk     - clock                                               |
// |            rst     - synchronous reset, active-high                      |
// |            pipe    - i_/d_ master side (slave modport)                   |
// |            mem     - m_ slave side (master modport)                      |
// |            grant_o - current owner: 00 none, 01 inst, 10 data            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter #(
   parameter int ADDR_W       = 30,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_arbiter_if.slave  pipe,
   mem_bus_arbiter_if.master mem,
   output logic [1:0]        grant_o
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   localparam logic [3:0] C_LIMIT   = 4'(STARVE_LIMIT);
   localparam logic [1:0] C_G_NONE  = 2'b00;
   localparam logic [1:0] C_G_INST  = 2'b01;
   localparam logic [1:0] C_G_DATA  = 2'b10;

   state_t            state_q, state_d;
   logic [3:0]        starve_q, starve_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [3:0]        be_q, be_d;

   // fields of the transaction on the bus this cycle, before reset gating
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_rd;
   logic              w_wr;
   logic [3:0]        w_be;
   logic [1:0]        w_grant;
   logic              w_win_i;
   logic              w_win_d;

   // IDLE arbitration: data wins unless fetch has been starved long enough
   always_comb begin
      w_win_i = 1'b0;
      w_win_d = 1'b0;
      if (state_q == IDLE) begin
         if ((pipe.d_read | pipe.d_write) && !(pipe.i_read && starve_q == C_LIMIT))
            w_win_d = 1'b1;
         else if (pipe.i_read)
            w_win_i = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      be_d     = be_q;
      w_addr   = '0;
      w_wdata  = '0;
      w_rd     = 1'b0;
      w_wr     = 1'b0;
      w_be     = 4'b0000;
      w_grant  = C_G_NONE;
      case (state_q)
         IDLE: begin
            if (w_win_d) begin
               // write takes precedence when both strobes are raised
               w_addr  = pipe.d_addr;
               w_wdata = pipe.d_dataD;
               w_wr    = pipe.d_write;
               w_rd    = ~pipe.d_write;
               w_be    = pipe.d_byteSel;
               w_grant = C_G_DATA;
               if (pipe.i_read && starve_q < C_LIMIT)
                  starve_d = starve_q + 4'd1;
            end else if (w_win_i) begin
               // fetch is a full-word read; write data is held at zero
               w_addr   = pipe.i_addr;
               w_rd     = 1'b1;
               w_be     = 4'b1111;
               w_grant  = C_G_INST;
               starve_d = 4'd0;
            end
            if ((w_win_d | w_win_i) && !mem.m_ready) begin
               addr_d  = w_addr;
               wdata_d = w_wdata;
               rd_d    = w_rd;
               wr_d    = w_wr;
               be_d    = w_be;
               state_d = w_win_d ? BUSY_D : BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            w_addr  = addr_q;
            w_wdata = wdata_q;
            w_rd    = rd_q;
            w_wr    = wr_q;
            w_be    = be_q;
            w_grant = (state_q == BUSY_D) ? C_G_DATA : C_G_INST;
            if (mem.m_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         starve_q <= 4'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         be_q     <= 4'b0000;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         be_q     <= be_d;
      end
   end

   // Outputs are forced inactive combinationally while reset is held, so an
   // abandoned transaction disappears from the bus in the reset cycle itself.
   assign mem.m_addr    = rst ? '0      : w_addr;
   assign mem.m_dataD   = rst ? '0      : w_wdata;
   assign mem.m_read    = ~rst & w_rd;
   assign mem.m_write   = ~rst & w_wr;
   assign mem.m_byteSel = rst ? 4'b0000 : w_be;
   assign grant_o       = rst ? C_G_NONE : w_grant;
   assign pipe.i_ready  = ~rst & mem.m_ready & (w_grant == C_G_INST);
   assign pipe.d_ready  = ~rst & mem.m_ready & (w_grant == C_G_DATA);
   assign pipe.i_dataQ  = mem.m_dataQ;
   assign pipe.d_dataQ  = mem.m_dataQ;
endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/100ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_bus_arbiter                                            |
// | Purpose  : Self-checking bench for mem_bus_arbiter. Queue-driven master  |
// |            models, a wait-state slave, and a transaction-level model    |
// |            compared against the DUT on every falling edge.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_bus_arbiter;
   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int LIMIT  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              rd;
      logic              wr;
      logic [3:0]        be;
   } dreq_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] grant;

   mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_bus_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .pipe   (bus),
      .mem    (bus),
      .grant_o(grant)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_s(input string name, input string act, input string exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   // ---------------- masters: hold the request at the queue head until ready
   logic [ADDR_W-1:0] iq[$];
   dreq_t             dq[$];

   initial begin : inst_master
      bus.i_read = 1'b0;
      bus.i_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) iq.delete();
         else if (bus.i_ready && iq.size() > 0) void'(iq.pop_front());
         @(posedge clk); #1;
         if (iq.size() > 0) begin
            bus.i_read = 1'b1;
            bus.i_addr = iq[0];
         end else begin
            bus.i_read = 1'b0;
            bus.i_addr = '0;
         end
      end
   end

   initial begin : data_master
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0;
      bus.d_dataD = '0; bus.d_byteSel = 4'b0000;
      forever begin
         @(negedge clk);
         if (rst) dq.delete();
         else if (bus.d_ready && dq.size() > 0) void'(dq.pop_front());
         @(posedge clk); #1;
         if (dq.size() > 0) begin
            bus.d_read = dq[0].rd; bus.d_write = dq[0].wr; bus.d_addr = dq[0].addr;
            bus.d_dataD = dq[0].data; bus.d_byteSel = dq[0].be;
         end else begin
            bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0;
            bus.d_dataD = '0; bus.d_byteSel = 4'b0000;
         end
      end
   end

   // ---------------- slave: completes after slave_wait extra cycles
   int slave_wait = 0;
   bit spurious   = 1'b0;
   int scnt       = 0;

   initial begin : slave
      bus.m_ready = 1'b0;
      bus.m_dataQ = '0;
      forever begin
         @(posedge clk); #2;
         if (rst) begin
            scnt = 0;
            bus.m_ready = 1'b0;
         end else begin
            if (bus.m_ready) scnt = 0;
            if (bus.m_read || bus.m_write) begin
               bus.m_ready = (scnt == slave_wait);
               scnt++;
            end else begin
               scnt = 0;
               bus.m_ready = spurious;
            end
            bus.m_dataQ = $urandom;
         end
      end
   end

   // ---------------- transaction-level model and per-cycle compare
   bit                mdl_busy = 1'b0;
   bit                mdl_is_d;
   logic [ADDR_W-1:0] mdl_addr;
   logic [DATA_W-1:0] mdl_data;
   logic              mdl_wr;
   logic [3:0]        mdl_be;
   int                mdl_starve = 0;
   int                mdl_starve_max = 0;

   int                n_rd = 0, n_iready = 0, n_dready = 0;
   string             glog = "";
   logic              l_d_wr, l_d_rd;
   logic [3:0]        l_d_be;
   logic [ADDR_W-1:0] l_d_addr;

   always @(negedge clk) begin : compare
      bit                v, is_d, d_wants;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
      logic              wr;
      logic [3:0]        be;
      chk("i_dataQ", bus.i_dataQ, bus.m_dataQ);
      chk("d_dataQ", bus.d_dataQ, bus.m_dataQ);
      if (rst) begin
         chk("rst_m_read",  bus.m_read, 0);
         chk("rst_m_write", bus.m_write, 0);
         chk("rst_m_addr",  bus.m_addr, 0);
         chk("rst_m_dataD", bus.m_dataD, 0);
         chk("rst_m_be",    bus.m_byteSel, 0);
         chk("rst_i_ready", bus.i_ready, 0);
         chk("rst_d_ready", bus.d_ready, 0);
         chk("rst_grant",   grant, 0);
         mdl_busy   = 1'b0;
         mdl_starve = 0;
      end else begin
         v = 1'b0; is_d = 1'b0; a = '0; wd = '0; wr = 1'b0; be = 4'b0000;
         if (mdl_busy) begin
            v = 1'b1; is_d = mdl_is_d; a = mdl_addr; wd = mdl_data; wr = mdl_wr; be = mdl_be;
         end else begin
            d_wants = bus.d_read | bus.d_write;
            if (bus.i_read && (!d_wants || mdl_starve >= LIMIT)) begin
               v = 1'b1; a = bus.i_addr; be = 4'b1111;
               mdl_starve = 0;
               glog = {glog, "I"};
            end else if (d_wants) begin
               v = 1'b1; is_d = 1'b1; a = bus.d_addr; wd = bus.d_dataD;
               wr = bus.d_write; be = bus.d_byteSel;
               if (bus.i_read && mdl_starve < LIMIT) mdl_starve++;
               glog = {glog, "D"};
            end
         end
         if (mdl_starve > mdl_starve_max) mdl_starve_max = mdl_starve;
         chk("m_addr",    bus.m_addr, a);
         chk("m_dataD",   bus.m_dataD, wd);
         chk("m_read",    bus.m_read, v && !(is_d && wr));
         chk("m_write",   bus.m_write, v && is_d && wr);
         chk("m_byteSel", bus.m_byteSel, be);
         chk("grant",     grant, !v ? 2'b00 : (is_d ? 2'b10 : 2'b01));
         chk("i_ready",   bus.i_ready, v && !is_d && bus.m_ready);
         chk("d_ready",   bus.d_ready, v && is_d && bus.m_ready);
         if (v) begin
            mdl_busy = !bus.m_ready;
            mdl_is_d = is_d; mdl_addr = a; mdl_data = wd; mdl_wr = wr; mdl_be = be;
         end
      end
      if (bus.m_read === 1'b1) n_rd++;
      if (bus.i_ready === 1'b1) n_iready++;
      if (bus.d_ready === 1'b1) begin
         n_dready++;
         l_d_wr = bus.m_write; l_d_rd = bus.m_read;
         l_d_be = bus.m_byteSel; l_d_addr = bus.m_addr;
      end
   end

   // ---------------- helpers (called at posedge+3, away from the compare edge)
   task automatic clear_stats();
      n_rd = 0; n_iready = 0; n_dready = 0; glog = "";
      mdl_starve_max = mdl_starve;
   endtask

   task automatic wait_done(input string name, input int maxc);
      int c = 0;
      while ((iq.size() > 0 || dq.size() > 0) && c < maxc) begin
         @(posedge clk); #3;
         c++;
      end
      total++;
      if (iq.size() > 0 || dq.size() > 0) begin
         bad++;
         $display("FAIL %s: timeout, inst queue %0d data queue %0d required 0/0", name, iq.size(), dq.size());
         iq.delete();
         dq.delete();
      end
      repeat (2) @(posedge clk);
      #3;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus
   initial begin : stim
      dreq_t r;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_grant", grant, 2'b00);
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #3;

      // T1: fetch alone, two wait states
      slave_wait = 2;
      clear_stats();
      iq.push_back(30'h100);
      wait_done("t1_done", 40);
      chk("t1_read_cycles", n_rd, 3);
      chk("t1_iready_cnt", n_iready, 1);
      chk("t1_dready_cnt", n_dready, 0);
      chk_s("t1_grants", glog, "I");

      // T2: simultaneous fetch and data write, zero-wait slave
      slave_wait = 0;
      clear_stats();
      iq.push_back(30'h200);
      r = '{addr: 30'h20, data: 32'hDEADBEEF, rd: 1'b0, wr: 1'b1, be: 4'b0011};
      dq.push_back(r);
      wait_done("t2_done", 40);
      chk_s("t2_grants", glog, "DI");
      chk("t2_d_be", l_d_be, 4'b0011);
      chk("t2_d_wr", l_d_wr, 1'b1);
      chk("t2_d_addr", l_d_addr, 30'h20);
      chk("t2_iready_cnt", n_iready, 1);
      chk("t2_starve", mdl_starve, 0);

      // T3: data hogs the bus, fetch must win the 5th decision
      slave_wait = 1;
      clear_stats();
      iq.push_back(30'h300);
      for (int k = 0; k < 6; k++) begin
         r = '{addr: 30'h400 + 30'(k), data: 32'h0, rd: 1'b1, wr: 1'b0, be: 4'b1111};
         dq.push_back(r);
      end
      wait_done("t3_done", 100);
      chk_s("t3_grants", glog, "DDDDIDD");
      chk("t3_starve_max", mdl_starve_max, LIMIT);
      chk("t3_starve_end", mdl_starve, 0);
      chk("t3_dready_cnt", n_dready, 6);
      chk("t3_iready_cnt", n_iready, 1);

      // T4: address change during a held data read must not reach the bus
      slave_wait = 3;
      clear_stats();
      r = '{addr: 30'h40, data: 32'h0, rd: 1'b1, wr: 1'b0, be: 4'b1111};
      dq.push_back(r);
      @(posedge clk); #3;
      dq[0].addr = 30'h80;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_m_addr", bus.m_addr, 30'h40);
         chk("t4_d_ready", bus.d_ready, (k == 3));
      end
      wait_done("t4_done", 40);
      chk_s("t4_grants", glog, "D");

      // T5: reset in the middle of a held fetch
      slave_wait = 5;
      clear_stats();
      iq.push_back(30'h500);
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_m_read", bus.m_read, 0);
      chk("t5_grant", grant, 2'b00);
      chk("t5_i_ready", bus.i_ready, 0);
      @(posedge clk); #3;
      @(negedge clk);
      chk("t5_m_read_next", bus.m_read, 0);
      chk("t5_grant_next", grant, 2'b00);
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #3;
      slave_wait = 0;
      clear_stats();
      iq.push_back(30'h600);
      wait_done("t5_done", 40);
      chk_s("t5_grants", glog, "I");
      chk("t5_iready_cnt", n_iready, 1);

      // T6: read and write strobes together perform a write
      slave_wait = 0;
      clear_stats();
      r = '{addr: 30'h60, data: 32'h1234_5678, rd: 1'b1, wr: 1'b1, be: 4'b1111};
      dq.push_back(r);
      wait_done("t6_done", 40);
      chk("t6_m_write", l_d_wr, 1'b1);
      chk("t6_m_read", l_d_rd, 1'b0);
      chk("t6_dready_cnt", n_dready, 1);

      // T7: slave ready with nothing requested is ignored
      clear_stats();
      spurious = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      spurious = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("t7_iready_cnt", n_iready, 0);
      chk("t7_dready_cnt", n_dready, 0);
      chk_s("t7_grants", glog, "");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
